// File: rtl/bridge_rx_if.sv
// Byte-stream input and decoded bus-transaction output of the host bridge receive parser.
interface bridge_rx_if #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 16
);
  logic [7:0]            data_i;
  logic                  valid_i;
  logic [ADDR_WIDTH-1:0] addr_o;
  logic [DATA_WIDTH-1:0] wdata_o;
  logic                  rw_o;
  logic                  valid_o;

  modport master (
    output data_i, valid_i,
    input  addr_o, wdata_o, rw_o, valid_o
  );

  modport slave (
    input  data_i, valid_i,
    output addr_o, wdata_o, rw_o, valid_o
  );
endinterface

// File: rtl/bridge_rx.sv
// ASCII read/write command parser: 'R'/'W' + hex address (+ hex data) + CR/LF
// becomes one bus transaction with a single-cycle valid strobe.
module bridge_rx #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  bridge_rx_if.slave  bus
);

  localparam int unsigned ADDR_DIGITS = ADDR_WIDTH / 4;
  localparam int unsigned DATA_DIGITS = DATA_WIDTH / 4;
  localparam int unsigned MAX_DIGITS  = (ADDR_DIGITS > DATA_DIGITS) ? ADDR_DIGITS : DATA_DIGITS;
  localparam int unsigned CNT_W       = (MAX_DIGITS > 1) ? $clog2(MAX_DIGITS) : 1;

  localparam logic [7:0] CH_R  = 8'h52;
  localparam logic [7:0] CH_W  = 8'h57;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;

  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_DIGITS - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    END  = 2'd3
  } state_t;

  state_t                r_state, w_state;
  logic                  r_is_write, w_is_write;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr;
  logic [DATA_WIDTH-1:0] r_data, w_data;
  logic [CNT_W-1:0]      r_cnt, w_cnt;
  logic [ADDR_WIDTH-1:0] r_addr_o, w_addr_o;
  logic [DATA_WIDTH-1:0] r_wdata_o, w_wdata_o;
  logic                  r_rw_o, w_rw_o;
  logic                  r_valid_o, w_valid_o;

  logic [7:0]            w_byte;
  logic                  w_is_hex;
  logic [3:0]            w_nib;

  assign w_byte = bus.data_i;

  // ASCII hex digit decode, both cases accepted
  always_comb begin
    w_is_hex = 1'b0;
    w_nib    = 4'h0;
    if (w_byte >= 8'h30 && w_byte <= 8'h39) begin
      w_is_hex = 1'b1;
      w_nib    = 4'(w_byte - 8'h30);
    end else if (w_byte >= 8'h41 && w_byte <= 8'h46) begin
      w_is_hex = 1'b1;
      w_nib    = 4'(w_byte - 8'h37);
    end else if (w_byte >= 8'h61 && w_byte <= 8'h66) begin
      w_is_hex = 1'b1;
      w_nib    = 4'(w_byte - 8'h57);
    end
  end

  // Next-state and next-register logic; 'R'/'W' restarts from any state
  always_comb begin
    w_state    = r_state;
    w_is_write = r_is_write;
    w_addr     = r_addr;
    w_data     = r_data;
    w_cnt      = r_cnt;
    w_addr_o   = r_addr_o;
    w_wdata_o  = r_wdata_o;
    w_rw_o     = r_rw_o;
    w_valid_o  = 1'b0;

    if (bus.valid_i) begin
      if (w_byte == CH_R || w_byte == CH_W) begin
        w_state    = ADDR;
        w_is_write = (w_byte == CH_W);
        w_addr     = '0;
        w_data     = '0;
        w_cnt      = '0;
      end else begin
        unique case (r_state)
          IDLE: ;
          ADDR: begin
            if (w_is_hex) begin
              w_addr = ADDR_WIDTH'({r_addr, w_nib});
              if (r_cnt == ADDR_LAST) begin
                w_state = r_is_write ? DATA : END;
                w_cnt   = '0;
              end else begin
                w_cnt = r_cnt + CNT_W'(1);
              end
            end else begin
              w_state = IDLE;
            end
          end
          DATA: begin
            if (w_is_hex) begin
              w_data = DATA_WIDTH'({r_data, w_nib});
              if (r_cnt == DATA_LAST) begin
                w_state = END;
                w_cnt   = '0;
              end else begin
                w_cnt = r_cnt + CNT_W'(1);
              end
            end else begin
              w_state = IDLE;
            end
          end
          END: begin
            if (w_byte == CH_CR || w_byte == CH_LF) begin
              w_addr_o  = r_addr;
              w_wdata_o = r_is_write ? r_data : '0;
              w_rw_o    = r_is_write;
              w_valid_o = 1'b1;
            end
            w_state = IDLE;
          end
          default: w_state = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_is_write <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_cnt      <= '0;
      r_addr_o   <= '0;
      r_wdata_o  <= '0;
      r_rw_o     <= 1'b0;
      r_valid_o  <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_is_write <= w_is_write;
      r_addr     <= w_addr;
      r_data     <= w_data;
      r_cnt      <= w_cnt;
      r_addr_o   <= w_addr_o;
      r_wdata_o  <= w_wdata_o;
      r_rw_o     <= w_rw_o;
      r_valid_o  <= w_valid_o;
    end
  end

  assign bus.addr_o  = r_addr_o;
  assign bus.wdata_o = r_wdata_o;
  assign bus.rw_o    = r_rw_o;
  assign bus.valid_o = r_valid_o;

endmodule

// File: doc/bridge_rx.md
# bridge_rx

Receive-side command parser for the host bridge. Consumes the byte stream from the UART receiver, decodes ASCII read/write request messages into bus transactions, and presents address, write data and direction to the core bus with a one-cycle valid strobe. It sits directly upstream of the bus and the read-response formatter. No backpressure: one message is parsed at a time, at full UART byte rate.

## Interface
- ADDR_WIDTH, 16, bus address width; must be a multiple of 4; address field = ADDR_WIDTH/4 hex digits
- DATA_WIDTH, 16, bus data width; must be a multiple of 4; data field = DATA_WIDTH/4 hex digits
- clk  in  1  single system clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- data_i  in  8  received byte from UART receiver
- valid_i  in  1  data_i valid this cycle; single-cycle strobe per byte
- addr_o  out  ADDR_WIDTH  decoded address, held until next completed message
- wdata_o  out  DATA_WIDTH  decoded write data; 0 for reads
- rw_o  out  1  1 = write, 0 = read
- valid_o  out  1  one-cycle pulse: addr_o/wdata_o/rw_o hold a new transaction

## Operation
- Message formats (bytes, in order):
  - read: 'R' (0x52), ADDR_WIDTH/4 hex digits MSB-first, terminator
  - write: 'W' (0x57), ADDR_WIDTH/4 address digits, DATA_WIDTH/4 data digits, terminator
  - terminator: CR (0x0D) or LF (0x0A); a CRLF pair completes one message, the trailing LF lands in IDLE and is ignored
- Hex digits: '0'-'9' (0x30-0x39), 'A'-'F' (0x41-0x46), 'a'-'f' (0x61-0x66). Nibble shifted into a working register: reg <= {reg[W-5:0], nibble}.
- States: IDLE, ADDR, DATA, END.
  - IDLE: 'R' → ADDR, is_write=0; 'W' → ADDR, is_write=1; all other bytes ignored. Entering ADDR clears working address/data registers and digit counter.
  - ADDR: hex digit → shift into address, count++. After the last address digit: write → DATA (counter cleared), read → END.
  - DATA: hex digit → shift into data; after the last digit → END.
  - END: CR/LF → commit. Copy working registers to addr_o/wdata_o (wdata_o=0 for reads), set rw_o=is_write, pulse valid_o, → IDLE.
- Errors: any byte not legal for the current state (non-hex in ADDR/DATA, non-terminator in END) silently drops the message → IDLE, with no valid_o. Exception: 'R' or 'W' in any non-IDLE state restarts a new message as if received in IDLE (resync).
- Bytes with valid_i=0 are ignored; data_i is don't-care then.
- Outputs change only on commit or reset.

## Timing
- Reset: state=IDLE; addr_o=0, wdata_o=0, rw_o=0, valid_o=0; working registers and counter cleared. Reset asserted mid-message discards it; rst has priority over valid_i in the same cycle.
- Latency: valid_o high the cycle after the clock edge that samples the terminator with valid_i=1; high for exactly one cycle.
- Back-to-back valid_i on consecutive cycles is supported, including a new 'R'/'W' on the cycle immediately after a terminator. valid_o never asserts on two consecutive cycles: a message is ≥ ADDR_WIDTH/4+2 bytes.
- addr_o/wdata_o/rw_o are registered, stable from the valid_o cycle until the next commit.
- Digit counter sized for max(ADDR_WIDTH, DATA_WIDTH)/4; no wrap: state changes exactly at the final digit.

## Test plan
- Read: bytes "R12AB\r\n", one per 10 cycles → single valid_o pulse, addr_o=0x12AB, rw_o=0, wdata_o=0; the trailing LF produces no second pulse.
- Write, mixed case, back-to-back bytes: "W00ffbeEF\n" on consecutive cycles → valid_o one cycle after the LF cycle, addr_o=0x00FF, wdata_o=0xBEEF, rw_o=1.
- Error drop: "R1G34\r" → no valid_o, outputs unchanged from the previous transaction; a following "R0001\r" → addr_o=0x0001.
- Resync: "W12R0042\r" → one read, addr_o=0x0042, rw_o=0; no write issued.
- Missing terminator: "R12345\r" (5 digits) → '5' in END drops the message; no valid_o; the parser then accepts "R0005\r".
- Reset mid-message: "W1234AB", assert rst for 1 cycle, then "CD\r" → no valid_o, all outputs 0; then "R00FF\r" → addr_o=0x00FF.
